// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush controller: stall encodings,
// exception codes and controller state encodings.
package pipe_stall_ctrl_pkg;

    localparam logic        Stop      = 1'b1;
    localparam logic        NoStop    = 1'b0;
    localparam logic        RstEnable = 1'b1;
    localparam logic [31:0] ZeroWord  = 32'h0000_0000;

    localparam logic [31:0] DEF_INT_VECTOR = 32'h0000_0020;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0040;

    localparam logic [31:0] EXC_NONE         = 32'h0;
    localparam logic [31:0] EXC_INT          = 32'h1;
    localparam logic [31:0] EXC_SYSCALL      = 32'h8;
    localparam logic [31:0] EXC_BREAK        = 32'h9;
    localparam logic [31:0] EXC_INVALID_INST = 32'ha;
    localparam logic [31:0] EXC_OVERFLOW     = 32'hc;
    localparam logic [31:0] EXC_TRAP         = 32'hd;
    localparam logic [31:0] EXC_ERET         = 32'he;

    // Bit order: [0]=pc [1]=if [2]=id [3]=ex [4]=mem [5]=wb
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_SETTLE = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/pipe_exc_vec.sv
// Maps a mem-stage exception code (and EPC for eret) to the redirect PC.
// Purely combinational so cp0 can reuse it.
module pipe_exc_vec
    import pipe_stall_ctrl_pkg::*;
#(
    parameter logic [31:0] INT_VECTOR = DEF_INT_VECTOR,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic [31:0] excepttype,
    input  logic [31:0] cp0_epc,
    output logic [31:0] new_pc
);

    always_comb begin
        new_pc = ZeroWord;
        case (excepttype)
            EXC_NONE: new_pc = ZeroWord;
            EXC_INT:  new_pc = INT_VECTOR;
            EXC_ERET: new_pc = cp0_epc;
            EXC_SYSCALL, EXC_BREAK, EXC_INVALID_INST, EXC_OVERFLOW, EXC_TRAP:
                      new_pc = EXC_VECTOR;
            default:  new_pc = EXC_VECTOR;
        endcase
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller with post-flush settle window and stall watchdog.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
//
// state     | meaning
// ST_RUN    | pipeline flowing, no stall last cycle
// ST_STALL  | at least one stage held last cycle
// ST_SETTLE | post-flush window, id/ex requests masked
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter logic [31:0] INT_VECTOR    = DEF_INT_VECTOR,
    parameter logic [31:0] EXC_VECTOR    = DEF_EXC_VECTOR,
    parameter logic [2:0]  SETTLE_CYCLES = 3'd1,
    parameter logic [15:0] STALL_TIMEOUT = 16'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_from_if,
    input  logic        stallreq_from_id,
    input  logic        stallreq_from_ex,
    input  logic        stallreq_from_mem,
    input  logic [31:0] excepttype,
    input  logic [31:0] cp0_epc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        stall_timeout,
`ifdef PIPE_PERF_CNT_EN
    output logic [31:0] perf_stall_cycles,
    output logic [15:0] perf_flush_cnt,
`endif
    output logic        ctrl_busy
);

    ctrl_state_e state;
    logic [2:0]  settle_cnt;
    logic [15:0] stall_cnt;
    logic [31:0] vec_pc;
    logic        settling;

    assign settling = (state == ST_SETTLE);

    pipe_exc_vec #(
        .INT_VECTOR (INT_VECTOR),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_exc_vec (
        .excepttype (excepttype),
        .cp0_epc    (cp0_epc),
        .new_pc     (vec_pc)
    );

    // id/ex requests during settle come from squashed instructions.
    always_comb begin
        stall = STALL_NONE;
        flush = 1'b0;
        if (rst != RstEnable) begin
            if (excepttype != ZeroWord)
                flush = 1'b1;
            else if (stallreq_from_mem == Stop)
                stall = STALL_MEM;
            else if (stallreq_from_ex == Stop && !settling)
                stall = STALL_EX;
            else if (stallreq_from_id == Stop && !settling)
                stall = STALL_ID;
            else if (stallreq_from_if == Stop)
                stall = STALL_IF;
        end
    end

    assign new_pc        = flush ? vec_pc : ZeroWord;
    assign stall_timeout = (rst != RstEnable) && (stall_cnt >= STALL_TIMEOUT);
    assign ctrl_busy     = (rst != RstEnable) && (state != ST_RUN);

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state      <= ST_RUN;
            settle_cnt <= 3'd0;
        end else if (flush) begin
            state      <= ST_SETTLE;
            settle_cnt <= SETTLE_CYCLES;
        end else begin
            case (state)
                ST_RUN:   if (stall != STALL_NONE) state <= ST_STALL;
                ST_STALL: if (stall == STALL_NONE) state <= ST_RUN;
                ST_SETTLE: begin
                    if (settle_cnt <= 3'd1) begin
                        state      <= (stall != STALL_NONE) ? ST_STALL : ST_RUN;
                        settle_cnt <= 3'd0;
                    end else begin
                        settle_cnt <= settle_cnt - 3'd1;
                    end
                end
                default:  state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable || flush || stall == STALL_NONE)
            stall_cnt <= 16'd0;
        else if (stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            perf_stall_cycles <= 32'd0;
            perf_flush_cnt    <= 16'd0;
        end else begin
            if (stall[0] == Stop) perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (flush)            perf_flush_cnt    <= perf_flush_cnt + 16'd1;
        end
    end
`endif

endmodule
